// File: rtl/serial_paralelo_rx_pkg.sv
// Shared definitions for the PHY serial receive path.
//   ComSym     : comma/alignment symbol, idle filler once the link is active
//   rx_state_e : receiver lock state (hunt for comma, count commas, active)
package serial_paralelo_rx_pkg;

  localparam logic [7:0] ComSym = 8'hBC;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StInit   = 2'd1,
    StActive = 2'd2
  } rx_state_e;

endpackage

// File: rtl/serial_paralelo_rx_shift_det.sv
// serial_shift_detector: 8-bit MSB-first shift register with comma comparator.
// Ports:
//   clk_i       : bit clock (clk_32f)
//   rst_i       : synchronous active-high reset, clears the register
//   data_i      : serial input bit
//   shreg_nxt_o : register contents including the bit being sampled this edge
//   com_match_o : shreg_nxt_o equals the comma symbol
module serial_shift_detector #(
  parameter logic [7:0] ComSymP = 8'hBC
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_i,
  output logic [7:0] shreg_nxt_o,
  output logic       com_match_o
);

  logic [7:0] shreg_q;

  // Look-ahead view so the FSM can act on a complete byte on the edge that samples its LSB.
  assign shreg_nxt_o = {shreg_q[6:0], data_i};
  assign com_match_o = (shreg_nxt_o == ComSymP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= 8'h00;
    end else begin
      shreg_q <= shreg_nxt_o;
    end
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: receive-side deserializer. Hunts bit-by-bit for the comma,
// requires BC_COUNT aligned commas to go active, then presents each non-comma
// byte in parallel, held for one byte slot.
// Ports:
//   clk_32f     : bit clock, one serial bit per rising edge
//   rst         : synchronous active-high reset
//   data_in     : serial bit stream, MSB first
//   active      : link active (sticky until reset)
//   data_out    : last received non-comma byte
//   valid_out   : data_out was received in the current byte slot
//   byte_strobe : one-cycle pulse at each aligned byte boundary
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter int unsigned BC_COUNT = 4,
  parameter logic [7:0]  COM_SYM  = ComSym
) (
  input  logic       clk_32f,
  input  logic       rst,
  input  logic       data_in,
  output logic       active,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe
);

  localparam int unsigned CntW = $clog2(BC_COUNT + 1);
  localparam logic [CntW-1:0] BcCountW = CntW'(BC_COUNT);

  rx_state_e       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0] com_cnt_q, com_cnt_d, com_cnt_inc;
  logic            active_q, active_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            strobe_q, strobe_d;

  logic [7:0] shreg_nxt;
  logic       com_match;
  logic       boundary;

  serial_shift_detector #(
    .ComSymP (COM_SYM)
  ) u_shift_det (
    .clk_i       (clk_32f),
    .rst_i       (rst),
    .data_i      (data_in),
    .shreg_nxt_o (shreg_nxt),
    .com_match_o (com_match)
  );

  assign boundary    = (bit_cnt_q == 3'd7);
  assign com_cnt_inc = (com_cnt_q == BcCountW) ? com_cnt_q : com_cnt_q + CntW'(1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    active_d  = active_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (com_match) begin
          bit_cnt_d = 3'd0;
          com_cnt_d = CntW'(1);
          strobe_d  = 1'b1;
          if (BC_COUNT == 1) begin
            state_d  = StActive;
            active_d = 1'b1;
          end else begin
            state_d = StInit;
          end
        end
      end
      StInit: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          strobe_d = 1'b1;
          if (com_match) begin
            com_cnt_d = com_cnt_inc;
            if (com_cnt_inc == BcCountW) begin
              state_d  = StActive;
              active_d = 1'b1;
            end
          end else begin
            // Broken comma run: drop alignment and resume the bit-level search.
            state_d   = StHunt;
            com_cnt_d = '0;
            bit_cnt_d = 3'd0;
          end
        end
      end
      StActive: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          strobe_d = 1'b1;
          if (!com_match) begin
            data_d  = shreg_nxt;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StHunt;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (rst) begin
      state_q   <= StHunt;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= '0;
      active_q  <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      active_q  <= active_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
    end
  end

  assign active      = active_q;
  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;

endmodule
